// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 8-digit seven-segment scanner.
package seg_pkg;

  localparam int unsigned N_DIG = 8;
  localparam int unsigned DIG_W = 4;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first so that HEX_SEG[h] selects digit h.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-word load channel: valid/ready handshake carrying digits, points and zero suppression.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic                     load_valid;
  logic                     load_ready;
  logic [N_DIG*DIG_W-1:0]   load_data;
  logic [N_DIG-1:0]         load_dp;
  logic                     load_lz;

  modport master (
    output load_valid, load_data, load_dp, load_lz,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, load_dp, load_lz,
    output load_ready
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [DIG_W-1:0] hex,
  output logic [6:0]       seg
);

  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with per-slot blanking and
// a shadow register that only updates the display at frame boundaries.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_scan_driver_if.slave     load,
  output logic [N_DIG-1:0]     dig_sel,
  output logic [6:0]           seg,
  output logic                 dp_n,
  output logic                 frame_tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(N_DIG);

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  scan_state_e            state_q, state_d;

  logic                   pend_q, pend_d;
  logic [N_DIG*DIG_W-1:0] shd_data_q, shd_data_d;
  logic [N_DIG-1:0]       shd_dp_q, shd_dp_d;
  logic                   shd_lz_q, shd_lz_d;
  logic [N_DIG*DIG_W-1:0] act_data_q, act_data_d;
  logic [N_DIG-1:0]       act_dp_q, act_dp_d;
  logic                   act_lz_q, act_lz_d;

  logic [N_DIG-1:0]       dig_sel_q, dig_sel_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_n_q, dp_n_d;
  logic                   tick_q, tick_d;

  logic                   wrap;
  logic                   frame_wrap;
  logic                   accept;
  logic [DIG_W-1:0]       cur_hex;
  logic [6:0]             dec_seg;
  logic [N_DIG-1:0]       supp;
  logic                   zero_run;

  assign wrap       = (presc_q == PW'(DIV - 1));
  assign frame_wrap = wrap && (idx_q == IW'(N_DIG - 1));
  assign accept     = load.load_valid && !pend_q;
  assign load.load_ready = !pend_q;

  // Prescaler and digit index
  always_comb begin
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = wrap ? idx_q + 1'b1 : idx_q;
  end

  // Next-state: the state mirrors which side of BLANK the next prescaler value lands on
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (presc_q == PW'(BLANK - 1)) state_d = ST_SHOW;
      ST_SHOW:  if (wrap)                     state_d = ST_BLANK;
      default:                                state_d = ST_BLANK;
    endcase
  end

  // Shadow accepts only while empty; it drains into the active word only at frame wrap
  always_comb begin
    pend_d     = pend_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    shd_lz_d   = shd_lz_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_lz_d   = act_lz_q;
    if (accept) begin
      pend_d     = 1'b1;
      shd_data_d = load.load_data;
      shd_dp_d   = load.load_dp;
      shd_lz_d   = load.load_lz;
    end
    if (frame_wrap && pend_q) begin
      pend_d     = 1'b0;
      act_data_d = shd_data_q;
      act_dp_d   = shd_dp_q;
      act_lz_d   = shd_lz_q;
    end
  end

  // Digit k is suppressed when it and every higher digit are zero; digit 0 never is
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int unsigned i = N_DIG - 1; i >= 1; i--) begin
      zero_run = zero_run && (act_data_q[i*DIG_W +: DIG_W] == '0);
      supp[i]  = act_lz_q && zero_run;
    end
  end

  assign cur_hex = act_data_q[idx_q*DIG_W +: DIG_W];

  seg_hex_decode u_hex_decode (
    .hex (cur_hex),
    .seg (dec_seg)
  );

  // Output decode, registered below for one cycle of latency to the pins
  always_comb begin
    dig_sel_d = '1;
    seg_d     = SEG_OFF;
    dp_n_d    = 1'b1;
    tick_d    = frame_wrap;
    if (state_q == ST_SHOW) begin
      dig_sel_d[idx_q] = 1'b0;
      seg_d            = supp[idx_q] ? SEG_OFF : dec_seg;
      dp_n_d           = !act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      state_q    <= ST_BLANK;
      pend_q     <= 1'b0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      shd_lz_q   <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_lz_q   <= 1'b0;
      dig_sel_q  <= '1;
      seg_q      <= SEG_OFF;
      dp_n_q     <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      shd_lz_q   <= shd_lz_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_lz_q   <= act_lz_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
      tick_q     <= tick_d;
    end
  end

  assign dig_sel    = dig_sel_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV=10, BLANK=2 (80-cycle frames).
module tb_seg_scan_driver;

  logic       clk;
  logic       rst;
  logic [7:0] dig_sel;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  int n_cmp;
  int n_bad;
  int k;

  seg_scan_driver_if lif ();

  seg_scan_driver #(.DIV(10), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif.slave),
    .dig_sel    (dig_sel),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [7:0] d, input logic [6:0] s, input logic p);
    chk(tag, {16'h0, dig_sel, seg, dp_n}, {16'h0, d, s, p});
  endtask

  // k counts rising edges since reset release; sampling happens on the falling edge after edge t
  task automatic goto(input int t);
    repeat (t - k) @(posedge clk);
    @(negedge clk);
    k = t;
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] p, input logic z);
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_dp    = p;
    lif.load_lz    = z;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    k     = 0;
    rst   = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_dp    = '0;
    lif.load_lz    = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk_pins("rst_pins", 8'hFF, 7'h7F, 1'b1);
    chk("rst_ready", {31'h0, lif.load_ready}, 32'h1);
    chk("rst_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;

    goto(2);  chk_pins("first_blank", 8'hFF, 7'h7F, 1'b1);
    goto(3);  chk_pins("idle_d0", 8'hFE, 7'h40, 1'b1);
    chk("idle_ready", {31'h0, lif.load_ready}, 32'h1);

    offer(32'h12345678, 8'h00, 1'b0);
    goto(4);
    lif.load_valid = 1'b0;
    chk("ready_low", {31'h0, lif.load_ready}, 32'h0);
    goto(10); chk_pins("slot0_last", 8'hFE, 7'h40, 1'b1);
    goto(11); chk_pins("slot1_blank", 8'hFF, 7'h7F, 1'b1);
    goto(13); chk_pins("no_tear_d1", 8'hFD, 7'h40, 1'b1);

    offer(32'h00000050, 8'h84, 1'b1);
    goto(20); chk("hold_ready", {31'h0, lif.load_ready}, 32'h0);
    goto(79);
    chk("tick_pre", {31'h0, frame_tick}, 32'h0);
    chk("ready_pre", {31'h0, lif.load_ready}, 32'h0);
    goto(80);
    chk("tick_f1", {31'h0, frame_tick}, 32'h1);
    chk("ready_back", {31'h0, lif.load_ready}, 32'h1);
    goto(81);
    lif.load_valid = 1'b0;
    chk("tick_one", {31'h0, frame_tick}, 32'h0);
    chk("ready_2nd", {31'h0, lif.load_ready}, 32'h0);

    goto(82);  chk_pins("w1_blank", 8'hFF, 7'h7F, 1'b1);
    goto(83);  chk_pins("w1_d0_first", 8'hFE, 7'h00, 1'b1);
    goto(90);  chk_pins("w1_d0_last", 8'hFE, 7'h00, 1'b1);
    goto(91);  chk_pins("w1_d1_blank", 8'hFF, 7'h7F, 1'b1);
    goto(93);  chk_pins("w1_d1", 8'hFD, 7'h78, 1'b1);
    goto(153); chk_pins("w1_d7", 8'h7F, 7'h79, 1'b1);

    goto(160);
    chk("tick_f2", {31'h0, frame_tick}, 32'h1);
    chk("ready_f2", {31'h0, lif.load_ready}, 32'h1);
    goto(163); chk_pins("lz_d0", 8'hFE, 7'h40, 1'b1);
    goto(173); chk_pins("lz_d1", 8'hFD, 7'h12, 1'b1);
    goto(183); chk_pins("lz_d2_dp", 8'hFB, 7'h7F, 1'b0);
    goto(213); chk_pins("lz_d5", 8'hDF, 7'h7F, 1'b1);
    goto(233); chk_pins("lz_d7_dp", 8'h7F, 7'h7F, 1'b0);
    goto(239); chk("tick_f3_pre", {31'h0, frame_tick}, 32'h0);
    goto(240); chk("tick_f3", {31'h0, frame_tick}, 32'h1);

    offer(32'hFFFFFFFF, 8'hFF, 1'b0);
    goto(241);
    lif.load_valid = 1'b0;
    chk("pend_ready", {31'h0, lif.load_ready}, 32'h0);
    goto(275); chk_pins("mid_d3", 8'hF7, 7'h7F, 1'b1);

    rst = 1'b1;
    #1;
    chk_pins("async_rst_pins", 8'hFF, 7'h7F, 1'b1);
    chk("async_rst_ready", {31'h0, lif.load_ready}, 32'h1);
    chk("async_rst_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;

    goto(2);  chk_pins("post_blank", 8'hFF, 7'h7F, 1'b1);
    goto(3);  chk_pins("post_d0", 8'hFE, 7'h40, 1'b1);
    chk("post_ready", {31'h0, lif.load_ready}, 32'h1);
    goto(80); chk("post_tick", {31'h0, frame_tick}, 32'h1);
    goto(83); chk_pins("post_no_pend_d0", 8'hFE, 7'h40, 1'b1);
    goto(93); chk_pins("post_no_pend_d1", 8'hFD, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles per digit slot (DIV >= 4).
REQ-002 SHALL have parameter BLANK, default 100, blanking cycles at the start of each slot (1 <= BLANK < DIV).
REQ-003 Port clk, input, 1, single system clock; all logic rising-edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port load_valid, input, 1, new display word offered.
REQ-006 Port load_ready, output, 1, shadow register free to accept a word.
REQ-007 Port load_data, input, 32, digit i = bits [4i+3:4i], hex 0-F, digit 0 rightmost.
REQ-008 Port load_dp, input, 8, decimal point per digit, 1 = lit.
REQ-009 Port load_lz, input, 1, leading-zero suppression enable for this word.
REQ-010 Port dig_sel, output, 8, active-low one-hot digit enable.
REQ-011 Port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-012 Port dp_n, output, 1, active-low decimal point.
REQ-013 Port frame_tick, output, 1, one-cycle pulse per completed 8-digit frame.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 and wrap; on wrap, 3-bit digit index SHALL advance, 7 wrapping to 0.
REQ-015 States SHALL be BLANK (prescaler < BLANK) and SHOW (prescaler >= BLANK); BLANK->SHOW at prescaler = BLANK, SHOW->BLANK at wrap.
REQ-016 In BLANK, dig_sel SHALL be 8'hFF, seg 7'h7F, dp_n 1.
REQ-017 In SHOW, dig_sel SHALL have only bit [index] low; seg/dp_n SHALL show the active digit at that index.
REQ-018 All outputs SHALL be registered: one clock of latency from prescaler/index state to pins.
REQ-019 Hex decode SHALL be the standard 0-F pattern (0=7'h40, 5=7'h12, 7=7'h78, 8=7'h00, F=7'h0E).
REQ-020 Handshake: transfer occurs on a cycle with load_valid & load_ready; word, dp and lz captured into shadow, load_ready falls next cycle.
REQ-021 Pending shadow SHALL be copied to the active register only on the index 7->0 wrap (no tearing mid-frame); load_ready SHALL return high the cycle after the copy.
REQ-022 load_valid while load_ready is low SHALL be ignored; the source must hold it.
REQ-023 frame_tick SHALL pulse high for exactly one cycle, aligned with the 7->0 wrap.
REQ-024 With lz set, digit k (7..1) SHALL be blanked (seg 7'h7F) when it and all higher digits are zero; digit 0 SHALL never be suppressed; dp SHALL still follow load_dp.
REQ-025 With no word ever loaded, the active register SHALL be zero, lz clear: display shows "00000000", no dp.

Reset
REQ-026 rst SHALL, asynchronously: dig_sel 8'hFF, seg 7'h7F, dp_n 1, frame_tick 0, load_ready 1.
REQ-027 rst SHALL clear prescaler, index, active/shadow registers and discard any pending word.
REQ-028 After rst release, the first slot SHALL be index 0 in BLANK state.

Structure
REQ-029 Shared package seg_pkg SHALL hold N_DIG = 8, digit width 4, and the 16-entry hex-to-segment constant table.
REQ-030 One sub-module seg_hex_decode (4-bit hex in, 7-bit active-low seg out, combinational) SHALL be instantiated.

Verification (DIV=10, BLANK=2)
REQ-031 Reset: assert rst -> dig_sel 8'hFF, seg 7'h7F, dp_n 1, load_ready 1 the same cycle.
REQ-032 Load 32'h12345678, dp 0 -> after next wrap, slot 0 cycles 2-9: dig_sel 8'hFE, seg 7'h00; slot 1: dig_sel 8'hFD, seg 7'h78.
REQ-033 Slot timing: pins off for 2 cycles, then lit for 8, per slot; frame_tick every 80 cycles.
REQ-034 Second load_valid while pending -> load_ready 0 until the cycle after the wrap; second word accepted then, no loss.
REQ-035 Load 32'h00000050, lz 1 -> digits 7..2 seg 7'h7F, digit 1 seg 7'h12, digit 0 seg 7'h40.
REQ-036 rst asserted mid-SHOW at index 3 with a word pending -> pins off immediately; after release, display "00000000", load_ready 1.
